// File: rtl/pipelined_hazard_unit_pkg.sv
// Shared types and constants for the ID-stage hazard unit.
package pipelined_hazard_unit_pkg;

  // Default width of the saturating stall/flush performance counters.
  localparam int CNT_W_DEFAULT = 16;

  // Register $zero: never a real producer, so it never causes a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Stall-sequence tracker, used for the counters and for debug.
  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL1 = 2'd1,
    HZ_STALL2 = 2'd2
  } hz_state_e;

  // Producer information for the instruction sitting in EX.
  typedef struct packed {
    logic       rw;  // RegWrite
    logic       mr;  // MemRead (load)
    logic [4:0] wr;  // destination register
  } ex_shadow_t;

  // Producer information for the instruction sitting in MEM. Only loads
  // matter here, because a load result is not available to ID before WB.
  typedef struct packed {
    logic       mr;
    logic [4:0] wr;
  } mem_shadow_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter: counts qualifying cycles and holds at all-ones.
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         Reset_L,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count one per qualifying cycle, stopping at the maximum value.
  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipelined_hazard_unit.sv
// ID-stage hazard unit for a 5-stage MIPS pipeline with branch/jr resolved
// in ID and no ALU forwarding into ID. Tracks its own EX/MEM producer
// shadows and decides stall/flush combinationally every cycle.
module pipelined_hazard_unit
  import pipelined_hazard_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [4:0]       ID_WriteReg,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             ID_Jr,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  ex_shadow_t  r_ex;
  mem_shadow_t r_mem;
  hz_state_e   r_state;

  logic w_match_ex;
  logic w_match_mem;
  logic w_br_or_jr;
  logic w_stall;
  logic w_ctl_xfer;
  logic w_flush;
  logic w_inc_stall;
  logic w_inc_flush;

  // True when the ID instruction actually reads register x (and x is not $zero).
  function automatic logic src_match(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rs,
    input logic       uses_rt,
    input logic [4:0] x
  );
    return (x != REG_ZERO) && ((uses_rs && (rs == x)) || (uses_rt && (rt == x)));
  endfunction

  assign w_match_ex  = src_match(ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, r_ex.wr);
  assign w_match_mem = src_match(ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, r_mem.wr);
  assign w_br_or_jr  = ID_Branch | ID_Jr;

  // Load-use in EX, any producer in EX feeding a compare/jr, or a load in
  // MEM feeding a compare/jr. A load feeding beq/jr hits the first term,
  // then the last one, giving two stall cycles.
  assign w_stall = (r_ex.mr & w_match_ex)
                 | (w_br_or_jr & r_ex.rw & w_match_ex)
                 | (w_br_or_jr & r_mem.mr & w_match_mem);

  // Control transfer resolved in ID; only acted on once the stall clears.
  assign w_ctl_xfer = ID_Jump | ID_Jr | (ID_Branch & BranchTaken);
  assign w_flush    = ~w_stall & w_ctl_xfer;

  // Pipeline-register control: reset forcing, then stall, then flush.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    if (!Reset_L) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (w_stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else if (w_ctl_xfer) begin
      IFIDFlush  = 1'b1;
    end
  end

  // Advance the producer shadows: MEM takes EX, EX takes ID or a bubble.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_mem.mr <= r_ex.mr;
      r_mem.wr <= r_ex.wr;
      if (w_stall) begin
        r_ex <= '0;
      end else begin
        r_ex.rw <= ID_RegWrite;
        r_ex.mr <= ID_MemRead;
        r_ex.wr <= ID_WriteReg;
      end
    end
  end

  // Track how many consecutive stall cycles have occurred.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state <= HZ_RUN;
    end else begin
      case (r_state)
        HZ_RUN:    if (w_stall) r_state <= HZ_STALL1;
        HZ_STALL1: r_state <= w_stall ? HZ_STALL2 : HZ_RUN;
        HZ_STALL2: r_state <= HZ_RUN;
        default:   r_state <= HZ_RUN;
      endcase
    end
  end

  // At most two consecutive stall cycles can arise from legal code.
  a_no_third_stall: assert property (
    @(posedge CLK) disable iff (!Reset_L) !((r_state == HZ_STALL2) && w_stall)
  );

  assign w_inc_stall = w_stall & Reset_L;
  assign w_inc_flush = w_flush & Reset_L;

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .inc     (w_inc_stall),
    .q       (StallCount)
  );

  hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .inc     (w_inc_flush),
    .q       (FlushCount)
  );

endmodule

// File: tb/tb_pipelined_hazard_unit.sv
// Scoreboard bench for pipelined_hazard_unit: directed instruction sequences
// with hand-derived per-cycle control expectations; counters are tracked
// from those expectations. A 4-bit-counter instance shares the stimulus.
module tb_pipelined_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rw;
    logic       mr;
    logic [4:0] wr;
    logic       br;
    logic       j;
    logic       jr;
    logic       tk;
  } id_t;

  typedef enum int {E_RUN, E_STALL, E_FLUSH, E_RST} exp_e;

  typedef struct {
    int         idx;
    logic [3:0] ctl;
    int         s;
    int         f;
    bit         known;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [4:0]  ID_Rs, ID_Rt, ID_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead;
  logic        ID_Branch, ID_Jump, ID_Jr, BranchTaken;

  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble;
  logic [15:0] StallCount, FlushCount;
  logic        PCWrite4, IFIDWrite4, IFIDFlush4, IDEXBubble4;
  logic [3:0]  StallCount4, FlushCount4;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_idx = 0;
  int   m_s      = 0;
  int   m_f      = 0;
  bit   m_known  = 1'b0;

  always #5 CLK = ~CLK;

  pipelined_hazard_unit dut (
    .CLK (CLK), .Reset_L (Reset_L),
    .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_UsesRs (ID_UsesRs), .ID_UsesRt (ID_UsesRt),
    .ID_RegWrite (ID_RegWrite), .ID_MemRead (ID_MemRead), .ID_WriteReg (ID_WriteReg),
    .ID_Branch (ID_Branch), .ID_Jump (ID_Jump), .ID_Jr (ID_Jr), .BranchTaken (BranchTaken),
    .PCWrite (PCWrite), .IFIDWrite (IFIDWrite), .IFIDFlush (IFIDFlush),
    .IDEXBubble (IDEXBubble), .StallCount (StallCount), .FlushCount (FlushCount)
  );

  pipelined_hazard_unit #(.CNT_W(4)) dut4 (
    .CLK (CLK), .Reset_L (Reset_L),
    .ID_Rs (ID_Rs), .ID_Rt (ID_Rt), .ID_UsesRs (ID_UsesRs), .ID_UsesRt (ID_UsesRt),
    .ID_RegWrite (ID_RegWrite), .ID_MemRead (ID_MemRead), .ID_WriteReg (ID_WriteReg),
    .ID_Branch (ID_Branch), .ID_Jump (ID_Jump), .ID_Jr (ID_Jr), .BranchTaken (BranchTaken),
    .PCWrite (PCWrite4), .IFIDWrite (IFIDWrite4), .IFIDFlush (IFIDFlush4),
    .IDEXBubble (IDEXBubble4), .StallCount (StallCount4), .FlushCount (FlushCount4)
  );

  // Instruction builders (register numbers: t0=8 t1=9 t2=10 t3=11 ra=31).
  function automatic id_t f_nop();
    id_t r = '0;
    return r;
  endfunction

  function automatic id_t f_lw(input logic [4:0] rt, input logic [4:0] base);
    id_t r = '0;
    r.rs = base; r.rt = rt; r.urs = 1'b1; r.rw = 1'b1; r.mr = 1'b1; r.wr = rt;
    return r;
  endfunction

  function automatic id_t f_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    id_t r = '0;
    r.rs = rs; r.rt = rt; r.urs = 1'b1; r.urt = 1'b1; r.rw = 1'b1; r.wr = rd;
    return r;
  endfunction

  function automatic id_t f_beq(input logic [4:0] rs, input logic [4:0] rt, input logic tk);
    id_t r = '0;
    r.rs = rs; r.rt = rt; r.urs = 1'b1; r.urt = 1'b1; r.br = 1'b1; r.tk = tk;
    return r;
  endfunction

  function automatic id_t f_j();
    id_t r = '0;
    r.j = 1'b1;
    return r;
  endfunction

  function automatic id_t f_jal();
    id_t r = '0;
    r.j = 1'b1; r.rw = 1'b1; r.wr = 5'd31;
    return r;
  endfunction

  function automatic id_t f_jr(input logic [4:0] rs);
    id_t r = '0;
    r.rs = rs; r.urs = 1'b1; r.jr = 1'b1;
    return r;
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
  function automatic logic [3:0] ctl_of(input exp_e e);
    case (e)
      E_STALL: return 4'b0001;
      E_FLUSH: return 4'b1110;
      E_RST:   return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  task automatic check(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got %0h expected %0h", idx, name, act, exp);
  endtask

  // Present one instruction in ID for one cycle and queue its expectation.
  task automatic step(input logic rst, input id_t ins, input exp_e e);
    exp_t x;
    Reset_L     = rst;
    ID_Rs       = ins.rs;
    ID_Rt       = ins.rt;
    ID_UsesRs   = ins.urs;
    ID_UsesRt   = ins.urt;
    ID_RegWrite = ins.rw;
    ID_MemRead  = ins.mr;
    ID_WriteReg = ins.wr;
    ID_Branch   = ins.br;
    ID_Jump     = ins.j;
    ID_Jr       = ins.jr;
    BranchTaken = ins.tk;
    x.idx   = step_idx;
    x.ctl   = ctl_of(e);
    x.s     = m_s;
    x.f     = m_f;
    x.known = m_known;
    exp_q.push_back(x);
    step_idx++;
    @(posedge CLK);
    #1;
    // Counters reflect the cycle just completed from the next cycle on.
    if (!rst) begin
      m_s = 0; m_f = 0; m_known = 1'b1;
    end else begin
      if (e == E_STALL) m_s++;
      if (e == E_FLUSH) m_f++;
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check(cur.idx, "ctl", {28'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}, {28'd0, cur.ctl});
      check(cur.idx, "ctl4", {28'd0, PCWrite4, IFIDWrite4, IFIDFlush4, IDEXBubble4}, {28'd0, cur.ctl});
      if (cur.known) begin
        check(cur.idx, "StallCount", {16'd0, StallCount}, cur.s);
        check(cur.idx, "FlushCount", {16'd0, FlushCount}, cur.f);
        check(cur.idx, "StallCount4", {28'd0, StallCount4}, (cur.s > 15) ? 15 : cur.s);
        check(cur.idx, "FlushCount4", {28'd0, FlushCount4}, (cur.f > 15) ? 15 : cur.f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    id_t tmp;
    Reset_L = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_WriteReg = '0;
    ID_Branch = 1'b0; ID_Jump = 1'b0; ID_Jr = 1'b0; BranchTaken = 1'b0;
    @(posedge CLK);
    #1;

    // Reset: outputs forced; counters cleared after the first edge.
    step(1'b0, f_nop(), E_RST);
    step(1'b0, f_nop(), E_RST);
    step(1'b1, f_nop(), E_RUN);

    // T1: load-use via rs, via rt, and a non-dependent follower.
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_add(5'd9, 5'd8, 5'd10), E_STALL);
    step(1'b1, f_add(5'd9, 5'd8, 5'd10), E_RUN);
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_add(5'd9, 5'd10, 5'd8), E_STALL);
    step(1'b1, f_add(5'd9, 5'd10, 5'd8), E_RUN);
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_add(5'd9, 5'd10, 5'd11), E_RUN);
    // Load followed by a jump whose rs field aliases t0 but is not read.
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    tmp = f_j();
    tmp.rs = 5'd8;
    step(1'b1, tmp, E_FLUSH);
    step(1'b1, f_nop(), E_RUN);

    // T2: ALU producer -> beq (1 stall), load -> beq (2 stalls then flush).
    step(1'b1, f_add(5'd8, 5'd9, 5'd10), E_RUN);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_STALL);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_RUN);
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b1), E_STALL);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b1), E_STALL);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b1), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);
    // Load -> jr: two stalls, then flush.
    step(1'b1, f_lw(5'd31, 5'd29), E_RUN);
    step(1'b1, f_jr(5'd31), E_STALL);
    step(1'b1, f_jr(5'd31), E_STALL);
    step(1'b1, f_jr(5'd31), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);
    // Load two ahead of beq: only the MEM-load term fires.
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_nop(), E_RUN);
    step(1'b1, f_beq(5'd9, 5'd8, 1'b1), E_STALL);
    step(1'b1, f_beq(5'd9, 5'd8, 1'b1), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);
    // ALU producer two ahead of beq: no stall.
    step(1'b1, f_add(5'd8, 5'd9, 5'd10), E_RUN);
    step(1'b1, f_nop(), E_RUN);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_RUN);
    // ALU producer of $ra -> jr: one stall, then flush.
    step(1'b1, f_add(5'd31, 5'd8, 5'd9), E_RUN);
    step(1'b1, f_jr(5'd31), E_STALL);
    step(1'b1, f_jr(5'd31), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);

    // T3: j / jal / jr $ra with no hazard.
    step(1'b1, f_j(), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);
    step(1'b1, f_jal(), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);
    step(1'b1, f_jr(5'd31), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);

    // T4: $zero never causes a hazard; untaken beq does nothing.
    step(1'b1, f_lw(5'd0, 5'd10), E_RUN);
    step(1'b1, f_add(5'd9, 5'd0, 5'd10), E_RUN);
    step(1'b1, f_beq(5'd10, 5'd11, 1'b0), E_RUN);
    step(1'b1, f_lw(5'd0, 5'd10), E_RUN);
    step(1'b1, f_beq(5'd0, 5'd0, 1'b0), E_RUN);
    step(1'b1, f_nop(), E_RUN);

    // T5: reset in STALL1 of a load-branch pair discards the pending stall.
    step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b1), E_STALL);
    step(1'b0, f_beq(5'd8, 5'd9, 1'b1), E_RST);
    step(1'b0, f_beq(5'd8, 5'd9, 1'b1), E_RST);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_RUN);
    step(1'b1, f_beq(5'd8, 5'd9, 1'b1), E_FLUSH);
    step(1'b1, f_nop(), E_RUN);

    // T6: 20 stall cycles; the 4-bit counter must hold at 4'hF.
    step(1'b0, f_nop(), E_RST);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, f_lw(5'd8, 5'd10), E_RUN);
      step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_STALL);
      step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_STALL);
      step(1'b1, f_beq(5'd8, 5'd9, 1'b0), E_RUN);
    end
    step(1'b1, f_nop(), E_RUN);
    step(1'b1, f_nop(), E_RUN);

    repeat (2) @(negedge CLK);
    check(step_idx, "queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
